// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver: LSB-first bits follow a one-cycle start sync, and each complete word is
// registered with a data_valid pulse. Optional saturating abort counter is enabled by DESER_ERRCNT_EN.
module deserializer_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // One-hot encoding so that a corrupted state register has illegal codes to recover from.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RECV = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = start ? RECV : IDLE;
      RECV: begin
        if (start) begin
          state_d = RECV;
        end else if (bit_cnt_q == LAST_BIT) begin
          state_d = IDLE;
        end else begin
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    word         = shift_q;
    word[bit_cnt_q] = serial_in;
    case (state_q)
      IDLE: begin
        if (start) begin
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      RECV: begin
        // A start inside a frame wins over the data bit, even on the final bit.
        if (start) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          shift_d     = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          data_out_d   = word;
          data_valid_d = 1'b1;
          bit_cnt_d    = '0;
          shift_d      = '0;
        end else begin
          shift_d   = word;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

`ifdef DESER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (frame_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_deserializer_rx.sv
// Self-checking bench for deserializer_rx: random frames, aborts and resets compared against
// expected pulse timelines derived from frame start cycles.
module tb_deserializer_rx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic [7:0]   err_count;

  deserializer_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .start(start),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [W-1:0] d; } ev_t;

  ev_t          valid_q[$];
  ev_t          exp_valid[$];
  int           err_q[$];
  int           exp_err[$];
  int           hold_viol = 0;
  logic [W-1:0] prev_d = '0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           total_aborts = 0;

  // Observe registered outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (data_valid === 1'b1) begin
      e.c = cyc; e.d = data_out;
      valid_q.push_back(e);
    end
    if (frame_err === 1'b1) err_q.push_back(cyc);
    if (rst_n === 1'b1 && data_valid !== 1'b1 && data_out !== prev_d) hold_viol++;
    prev_d = data_out;
  end

  function automatic int exp_errcnt(int n);
`ifdef DESER_ERRCNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic clear_queues();
    valid_q.delete(); exp_valid.delete(); err_q.delete(); exp_err.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); start = 1'b0; serial_in = 1'($urandom);
    end
  endtask

  task automatic send_start(output int s);
    @(negedge clk); start = 1'b1; serial_in = 1'($urandom); s = cyc;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); start = 1'b0; serial_in = w[k];
    end
  endtask

  // Model: a frame started in cycle s yields its word on data_out in cycle s+W+1.
  task automatic send_frame(input logic [W-1:0] w, output int s);
    ev_t e;
    send_start(s);
    send_bits(w, W);
    e.c = s + W + 1; e.d = w;
    exp_valid.push_back(e);
  endtask

  // Model: a start inside a frame in cycle s gives frame_err in cycle s+1.
  task automatic send_abort(output int s);
    send_start(s);
    exp_err.push_back(s + 1);
    total_aborts++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; serial_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    start = 1'b0; rst_n = 1'b1;
    clear_queues();
    idle(2 * W);
    n_checks++; if (valid_q.size() != 0) begin n_fail++; $display("FAIL reset_ignore_serial: got %0d valid pulses expected 0", valid_q.size()); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int s;
    clear_queues();
    send_frame(8'hA5, s);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      send_frame(W'($urandom), s);
    end
    idle(3);
    n_checks++; if (valid_q.size() != exp_valid.size()) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", valid_q.size(), exp_valid.size()); end
    for (int i = 0; i < valid_q.size() && i < exp_valid.size(); i++) begin
      n_checks++;
      if (valid_q[i].c != exp_valid[i].c || valid_q[i].d !== exp_valid[i].d) begin
        n_fail++; $display("FAIL single_word%0d: got %h at cycle %0d expected %h at cycle %0d", i, valid_q[i].d, valid_q[i].c, exp_valid[i].d, exp_valid[i].c);
      end
    end
    n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL single_no_err: got %0d frame_err pulses expected 0", err_q.size()); end
    $display("test_single done: %0d words", exp_valid.size());
  endtask

  task automatic test_paired();
    int s0, s1;
    clear_queues();
    send_frame(8'h3C, s0);
    idle(1);
    send_frame(8'hC3, s1);
    idle(3);
    n_checks++; if (valid_q.size() != 2) begin n_fail++; $display("FAIL paired_count: got %0d expected 2", valid_q.size()); end
    if (valid_q.size() == 2) begin
      n_checks++; if (valid_q[1].c - valid_q[0].c != W + 2) begin n_fail++; $display("FAIL paired_spacing: got %0d expected %0d", valid_q[1].c - valid_q[0].c, W + 2); end
      n_checks++; if (valid_q[0].d !== 8'h3C || valid_q[1].d !== 8'hC3) begin n_fail++; $display("FAIL paired_data: got %h %h expected 3c c3", valid_q[0].d, valid_q[1].d); end
      n_checks++; if (valid_q[0].c != exp_valid[0].c) begin n_fail++; $display("FAIL paired_latency: got cycle %0d expected %0d", valid_q[0].c, exp_valid[0].c); end
    end
    $display("test_paired done");
  endtask

  task automatic test_abort();
    int s, sa;
    clear_queues();
    send_start(s);
    send_bits(W'($urandom), 3);
    send_abort(sa);
    send_bits(8'h5A, W);
    exp_valid.push_back('{c: sa + W + 1, d: 8'h5A});
    idle(2);
    // Abort landing on the final bit position.
    send_start(s);
    send_bits(W'($urandom), W - 1);
    send_abort(sa);
    send_bits(8'h96, W);
    exp_valid.push_back('{c: sa + W + 1, d: 8'h96});
    idle(3);
    n_checks++; if (err_q.size() != 2) begin n_fail++; $display("FAIL abort_err_count: got %0d expected 2", err_q.size()); end
    for (int i = 0; i < err_q.size() && i < 2; i++) begin
      n_checks++; if (err_q[i] != exp_err[i]) begin n_fail++; $display("FAIL abort_err_cycle%0d: got %0d expected %0d", i, err_q[i], exp_err[i]); end
    end
    n_checks++; if (valid_q.size() != 2) begin n_fail++; $display("FAIL abort_valid_count: got %0d expected 2", valid_q.size()); end
    for (int i = 0; i < valid_q.size() && i < 2; i++) begin
      n_checks++;
      if (valid_q[i].c != exp_valid[i].c || valid_q[i].d !== exp_valid[i].d) begin
        n_fail++; $display("FAIL abort_word%0d: got %h at cycle %0d expected %h at cycle %0d", i, valid_q[i].d, valid_q[i].c, exp_valid[i].d, exp_valid[i].c);
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_reset_mid();
    int s;
    clear_queues();
    send_frame(8'h7E, s);
    idle(1);
    send_start(s);
    send_bits(8'hFF, 4);
    @(negedge clk); rst_n = 1'b0; start = 1'b0;
    #1;
    n_checks++; if (data_out !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h %b %b %0d expected 00 0 0 0", data_out, data_valid, frame_err, err_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total_aborts = 0;
    idle(W + 3);
    send_frame(8'h81, s);
    idle(3);
    n_checks++; if (valid_q.size() != 2) begin n_fail++; $display("FAIL midreset_valid_count: got %0d expected 2", valid_q.size()); end
    if (valid_q.size() == 2) begin
      n_checks++; if (valid_q[1].d !== 8'h81 || valid_q[1].c != exp_valid[1].c) begin
        n_fail++; $display("FAIL midreset_next_frame: got %h at %0d expected 81 at %0d", valid_q[1].d, valid_q[1].c, exp_valid[1].c);
      end
    end
    n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL midreset_no_err: got %0d expected 0", err_q.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    clear_queues();
    send_frame(8'h11, s0);
    send_frame(8'h22, s1);
    idle(3);
    n_checks++; if (valid_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", valid_q.size()); end
    if (valid_q.size() == 2) begin
      n_checks++; if (valid_q[1].c - valid_q[0].c != W + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", valid_q[1].c - valid_q[0].c, W + 1); end
      n_checks++; if (valid_q[0].d !== 8'h11 || valid_q[1].d !== 8'h22) begin n_fail++; $display("FAIL b2b_data: got %h %h expected 11 22", valid_q[0].d, valid_q[1].d); end
    end
    n_checks++; if (err_q.size() != 0) begin n_fail++; $display("FAIL b2b_no_err: got %0d expected 0", err_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_errcnt();
    int s, sa;
    logic [W-1:0] w;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total_aborts = 0;
    clear_queues();
    send_start(s);
    repeat (3) begin
      send_bits(W'($urandom), $urandom_range(0, W - 1));
      send_abort(sa);
    end
    w = W'($urandom);
    send_bits(w, W);
    idle(3);
    n_checks++; if (err_count !== 8'(exp_errcnt(total_aborts))) begin n_fail++; $display("FAIL errcnt_after3: got %0d expected %0d", err_count, exp_errcnt(total_aborts)); end
    n_checks++; if (err_q.size() != 3) begin n_fail++; $display("FAIL errcnt_pulses3: got %0d expected 3", err_q.size()); end
    for (int i = 0; i < err_q.size() && i < 3; i++) begin
      n_checks++; if (err_q[i] != exp_err[i]) begin n_fail++; $display("FAIL errcnt_cycle%0d: got %0d expected %0d", i, err_q[i], exp_err[i]); end
    end
    n_checks++; if (valid_q.size() != 1 || (valid_q.size() == 1 && (valid_q[0].d !== w || valid_q[0].c != sa + W + 1))) begin
      n_fail++; $display("FAIL errcnt_frame_after_abort: got %0d pulses expected 1 of %h at %0d", valid_q.size(), w, sa + W + 1);
    end
    send_start(s);
    repeat (300) begin
      send_bits(W'($urandom), $urandom_range(0, 2));
      send_abort(sa);
    end
    send_bits(W'($urandom), W);
    idle(3);
    n_checks++; if (err_count !== 8'(exp_errcnt(total_aborts))) begin n_fail++; $display("FAIL errcnt_saturate: got %0d expected %0d", err_count, exp_errcnt(total_aborts)); end
    n_checks++; if (err_q.size() != total_aborts) begin n_fail++; $display("FAIL errcnt_pulses: got %0d expected %0d", err_q.size(), total_aborts); end
    n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL data_out_hold: got %0d unflagged changes expected 0", hold_viol); end
    $display("test_errcnt done: %0d aborts, err_count %0d", total_aborts, err_count);
  endtask

  initial begin
    test_reset();
    test_single();
    test_paired();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_errcnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializer_rx.md
DESERIALIZER_RX -- requirements
Module: deserializer_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port serial_in  input  1  serial data, LSB first, one bit per clk.
REQ-005 The block SHALL have port start  input  1  frame sync; high for one clk immediately before bit 0.
REQ-006 The block SHALL have port data_out  output  WIDTH  last completely received word, registered.
REQ-007 The block SHALL have port data_valid  output  1  one-clk pulse marking a new data_out value.
REQ-008 The block SHALL have port frame_err  output  1  one-clk pulse marking an aborted frame.
REQ-009 The block SHALL have port err_count  output  8  saturating count of aborted frames (see Configuration).

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and RECV.
REQ-011 In IDLE, start sampled high SHALL clear the bit counter and the shift register and move to RECV.
REQ-012 In IDLE, start low SHALL keep the block in IDLE; serial_in is ignored.
REQ-013 In RECV, the block SHALL sample serial_in once per clk into bit position bit_cnt, bit_cnt 0..WIDTH-1, width $clog2(WIDTH).
REQ-014 When start is high for cycle S, bits SHALL be sampled in cycles S+1..S+WIDTH, bit k in cycle S+1+k.
REQ-015 After the sample at bit_cnt == WIDTH-1, the assembled word SHALL load data_out, data_valid SHALL be high for exactly cycle S+WIDTH+1, and the FSM SHALL return to IDLE.
REQ-016 data_out SHALL hold its value between frames; it changes only together with a data_valid pulse.
REQ-017 A start sampled in cycle S+WIDTH+1, the data_valid cycle, SHALL begin a new frame normally with no error; the word period is then WIDTH+1 clk.
REQ-018 A start sampled high in RECV SHALL abort the current frame: no data_valid, data_out unchanged, frame_err high for the next cycle, bit_cnt cleared, stay in RECV, and that start cycle counts as S of the new frame.
REQ-019 The partial word of an aborted frame SHALL never appear on data_out.
REQ-020 The bit counter SHALL never exceed WIDTH-1; no wrap-around beyond the final bit.
REQ-021 An illegal FSM encoding SHALL return to IDLE on the next clk.
REQ-022 Latency from bit WIDTH-1 on serial_in to data_valid SHALL be exactly 1 clk.

Reset
REQ-023 While rst_n is low, the FSM SHALL be IDLE and bit_cnt, shift register, data_out, data_valid, frame_err and err_count SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial word without a data_valid or frame_err pulse.
REQ-025 After rst_n deasserts, the block SHALL ignore serial_in until the first start is sampled high.

Configuration
REQ-026 With macro DESER_ERRCNT_EN defined, err_count SHALL increment on every frame_err pulse and saturate at 255.
REQ-027 Without DESER_ERRCNT_EN, err_count SHALL be tied to 0 and no counter register SHALL be built.
REQ-028 frame_err and all other behaviour SHALL be identical with and without DESER_ERRCNT_EN.

Verification
REQ-029 Stimulus: start in cycle S, then serial_in driven with 0xA5 LSB first. Required response: data_out = 0xA5 and data_valid high only in cycle S+9; frame_err stays 0.
REQ-030 Stimulus: a paired serializer sends 0x3C then 0xC3 with period WIDTH+2. Required response: two data_valid pulses 10 clk apart, carrying 0x3C then 0xC3.
REQ-031 Stimulus: start, 3 bits, a second start, then 0x5A. Required response: frame_err pulse once, no data_valid for the first frame, then data_out = 0x5A.
REQ-032 Stimulus: rst_n pulsed low after 4 bits of 0xFF. Required response: all outputs 0 and no pulses; the next frame 0x81 is received correctly.
REQ-033 Stimulus: start in the data_valid cycle of 0x11, then 0x22 follows. Required response: back-to-back valid pulses 9 clk apart with no error.
REQ-034 With DESER_ERRCNT_EN defined, stimulus: 3 aborts, then 300 aborts. Required response: err_count = 3 after the first group, then saturates at 255; without the macro, err_count stays 0.
